hour_counter: RTL and testbench
===============================

HOUR_COUNTER -- requirements
Module: hour_counter

Interface
REQ-001 The module SHALL have these ports; reset rst is asynchronous, active-high; the clock is minute_clk:
  minute_clk  in   1  clock; all state updates on rising edge
  rst         in   1  asynchronous, active-high reset
  en          in   1  block enable; low = hold count, suppress pulses
  min_carry   in   1  one-cycle minute-rollover strobe from the minute stage, synchronous to minute_clk
  mode_12h    in   1  1 = 12-hour display format, 0 = 24-hour
  set_req     in   1  time-set request, level, held until set_ack/set_err seen
  set_hour    in   5  requested hour, 0..23 (24-hour encoding)
  hour_w      out  5  current hour, 0..23, registered
  hour_disp   out  5  display hour: 0..23 (24h) or 1..12 (12h)
  pm          out  1  1 when hour_w >= 12, independent of mode_12h
  day_carry   out  1  one-cycle pulse on 23 -> 0 wrap
  set_ack     out  1  one-cycle pulse when set_hour is loaded
  set_err     out  1  one-cycle pulse when set_hour > 23 is rejected

Function
REQ-002 The FSM SHALL have the states RUN, LOAD and WAIT_DROP.
REQ-003 In RUN with en=1, min_carry=1 and set_req=0, hour_w SHALL increment by 1 on that edge.
REQ-004 When hour_w=23 and an increment occurs, hour_w SHALL become 0 and day_carry SHALL be 1 for exactly the following cycle.
REQ-005 In RUN with en=1, set_req=1 SHALL move the FSM to LOAD; a min_carry on the same edge SHALL be discarded (set wins).
REQ-006 In LOAD with set_hour<=23, hour_w SHALL take set_hour and set_ack SHALL pulse for one cycle.
REQ-007 In LOAD with set_hour>23, hour_w SHALL hold and set_err SHALL pulse for one cycle.
REQ-008 In both LOAD cases the FSM SHALL go to WAIT_DROP; set_ack or set_err SHALL be registered and visible 2 edges after set_req is first sampled.
REQ-009 WAIT_DROP SHALL return to RUN on the first edge where set_req=0; it SHALL NOT issue a second ack while set_req stays high.
REQ-010 min_carry SHALL be ignored in LOAD and WAIT_DROP, with no increment and no day_carry.
REQ-011 While en=0, hour_w SHALL hold, day_carry, set_ack and set_err SHALL be 0, and the FSM SHALL be forced to RUN; a set in progress is abandoned without ack.
REQ-012 hour_disp and pm SHALL be a combinational decode of registered hour_w, adding no latency.
REQ-013 The 12-hour decode SHALL map 0->12 with pm=0, 1..11->same with pm=0, 12->12 with pm=1, and 13..23->hour-12 with pm=1.
REQ-014 In 24-hour mode hour_disp SHALL equal hour_w; a mode_12h change SHALL alter the display only, never hour_w.
REQ-015 hour_w SHALL never hold a value outside 0..23; arithmetic SHALL be 5-bit with an explicit compare-to-23 wrap.

Reset
REQ-016 On rst=1, asynchronously: hour_w=0, day_carry=0, set_ack=0, set_err=0, FSM=RUN; hour_disp/pm follow the decode (12/0 in 12h mode).
REQ-017 Reset mid-set SHALL abandon the set without any ack or err pulse; after release the block SHALL be in RUN with hour_w=0.
REQ-018 All pulse outputs SHALL be deasserted on the first edge after reset release unless their own condition holds.

Structure
REQ-019 Shared package clock_pkg SHALL hold HOUR_MAX=23, MIN_MAX=59, HOUR_W=5, MIN_W=7 and the hour FSM state enum.
REQ-020 The 12/24-hour decode SHALL be a sub-module named hour_fmt, purely combinational, with inputs hour_w and mode_12h and outputs hour_disp and pm.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - Reset, then 24 min_carry pulses with en=1 -> hour_w steps 1..23 then 0; day_carry high only in the cycle after the 24th pulse.
  - set_req=1, set_hour=17 held 4 cycles -> set_ack once at edge 2; hour_w=17; hour_disp=5, pm=1 with mode_12h=1; no further ack until set_req drops.
  - set_req=1, set_hour=25 -> set_err once; hour_w unchanged; set_ack never asserted.
  - set_req and min_carry asserted on the same edge with hour_w=9 -> hour_w=set_hour, no increment; min_carry pulses during WAIT_DROP are ignored.
  - en=0 during 3 min_carry pulses at hour_w=23 -> hour_w stays 23, no day_carry; en=1 plus 1 pulse -> hour_w=0, day_carry pulses.
  - rst asserted in LOAD -> immediate hour_w=0, no ack; mode_12h toggled at hour_w=0 -> hour_disp alternates 12/0, pm=0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants and the hour-stage FSM state type for the clock datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 7;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 7'd59;

  // Hour-stage control: counting, applying a set request, waiting for the
  // requester to drop set_req before accepting another one.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD      = 2'd1,
    WAIT_DROP = 2'd2
  } hour_state_e;

endpackage

// File: rtl/hour_fmt.sv
// 12/24-hour display decode of the registered hour value.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
module hour_fmt
  import clock_pkg::*;
(
  input  logic [HOUR_W-1:0] hour_w,
  input  logic              mode_12h,
  output logic [HOUR_W-1:0] hour_disp,
  output logic              pm
);

  // Midnight and noon both show 12; afternoon hours fold down by 12.
  always_comb begin
    hour_disp = hour_w;
    pm        = (hour_w >= 5'd12);
    if (mode_12h) begin
      if (hour_w == 5'd0) begin
        hour_disp = 5'd12;
      end else if (hour_w > 5'd12) begin
        hour_disp = hour_w - 5'd12;
      end
    end
  end

endmodule

// File: rtl/hour_counter.sv
// Hour stage of the clock: counts minute rollovers, wraps 23->0, accepts time-set requests.
// Latency: hour_w/day_carry update on the carry edge; set_ack/set_err appear 2 edges after set_req is sampled.
// Backpressure: set_req is a held level; one ack/err per request, next accepted only after set_req drops.
module hour_counter
  import clock_pkg::*;
(
  input  logic              minute_clk,
  input  logic              rst,
  input  logic              en,
  input  logic              min_carry,
  input  logic              mode_12h,
  input  logic              set_req,
  input  logic [HOUR_W-1:0] set_hour,
  output logic [HOUR_W-1:0] hour_w,
  output logic [HOUR_W-1:0] hour_disp,
  output logic              pm,
  output logic              day_carry,
  output logic              set_ack,
  output logic              set_err
);

  hour_state_e       state_q, state_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              day_carry_q, day_carry_d;
  logic              set_ack_q, set_ack_d;
  logic              set_err_q, set_err_d;

  // Next-state and next-output computation; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    hour_d      = hour_q;
    day_carry_d = 1'b0;
    set_ack_d   = 1'b0;
    set_err_d   = 1'b0;

    if (!en) begin
      // Disabled: hold the hour and abandon any set in flight.
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (set_req) begin
            // A set request takes priority over a coincident carry.
            state_d = LOAD;
          end else if (min_carry) begin
            if (hour_q == HOUR_MAX) begin
              hour_d      = '0;
              day_carry_d = 1'b1;
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end
        end
        LOAD: begin
          if (set_hour > HOUR_MAX) begin
            set_err_d = 1'b1;
          end else begin
            hour_d    = set_hour;
            set_ack_d = 1'b1;
          end
          state_d = WAIT_DROP;
        end
        WAIT_DROP: begin
          if (!set_req) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State and registered outputs; asynchronous reset returns to RUN at hour 0.
  always_ff @(posedge minute_clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      hour_q      <= '0;
      day_carry_q <= 1'b0;
      set_ack_q   <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      day_carry_q <= day_carry_d;
      set_ack_q   <= set_ack_d;
      set_err_q   <= set_err_d;
    end
  end

  assign hour_w    = hour_q;
  assign day_carry = day_carry_q;
  assign set_ack   = set_ack_q;
  assign set_err   = set_err_q;

  hour_fmt u_hour_fmt (
    .hour_w    (hour_q),
    .mode_12h  (mode_12h),
    .hour_disp (hour_disp),
    .pm        (pm)
  );

endmodule

// File: tb/tb_hour_counter.sv
// Self-checking bench for hour_counter: vector table, directed corner sequences, random vs. model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: set_req driven as a held level by the bench.
module tb_hour_counter;

  logic       minute_clk = 1'b0;
  logic       rst        = 1'b1;
  logic       en         = 1'b0;
  logic       min_carry  = 1'b0;
  logic       mode_12h   = 1'b0;
  logic       set_req    = 1'b0;
  logic [4:0] set_hour   = 5'd0;
  logic [4:0] hour_w;
  logic [4:0] hour_disp;
  logic       pm;
  logic       day_carry;
  logic       set_ack;
  logic       set_err;

  hour_counter dut (
    .minute_clk (minute_clk),
    .rst        (rst),
    .en         (en),
    .min_carry  (min_carry),
    .mode_12h   (mode_12h),
    .set_req    (set_req),
    .set_hour   (set_hour),
    .hour_w     (hour_w),
    .hour_disp  (hour_disp),
    .pm         (pm),
    .day_carry  (day_carry),
    .set_ack    (set_ack),
    .set_err    (set_err)
  );

  always #5 minute_clk = ~minute_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: hour as an integer, set progress as "edges since request seen".
  int m_hour  = 0;
  int m_phase = 0; // 0 idle, 1 request accepted, 2 answered and waiting for drop
  int m_dc = 0, m_ack = 0, m_err = 0;

  function automatic int disp_of(input int h, input int m12);
    if (m12 == 0) return h;
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  task automatic model_edge();
    m_dc = 0; m_ack = 0; m_err = 0;
    if (!en) begin
      m_phase = 0;
    end else if (m_phase == 1) begin
      if (int'(set_hour) < 24) begin m_hour = int'(set_hour); m_ack = 1; end
      else m_err = 1;
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (!set_req) m_phase = 0;
    end else if (set_req) begin
      m_phase = 1;
    end else if (min_carry) begin
      if (m_hour == 23) m_dc = 1;
      m_hour = (m_hour + 1) % 24;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge minute_clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " hour"}, int'(hour_w), m_hour);
    check({tag, " disp"}, int'(hour_disp), disp_of(m_hour, int'(mode_12h)));
    check({tag, " pm"}, int'(pm), (m_hour >= 12) ? 1 : 0);
    check({tag, " day_carry"}, int'(day_carry), m_dc);
    check({tag, " set_ack"}, int'(set_ack), m_ack);
    check({tag, " set_err"}, int'(set_err), m_err);
  endtask

  // Assert reset away from the edge, check async effect, release after an edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("reset hour", int'(hour_w), 0);
    check("reset day_carry", int'(day_carry), 0);
    check("reset set_ack", int'(set_ack), 0);
    check("reset set_err", int'(set_err), 0);
    m_hour = 0; m_phase = 0; m_dc = 0; m_ack = 0; m_err = 0;
    @(posedge minute_clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    int en, mc, m12, sr, sh;
    int e_hour, e_disp, e_pm, e_dc, e_ack, e_err;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1,1,0,0,0,  1, 1,0,0,0,0};
    tbl[1]  = '{1,0,1,1,17, 1, 1,0,0,0,0};
    tbl[2]  = '{1,0,1,1,17, 17,5,1,0,1,0};
    tbl[3]  = '{1,1,1,1,17, 17,5,1,0,0,0};
    tbl[4]  = '{1,0,1,1,17, 17,5,1,0,0,0};
    tbl[5]  = '{1,0,0,0,17, 17,17,1,0,0,0};
    tbl[6]  = '{1,1,0,1,25, 17,17,1,0,0,0};
    tbl[7]  = '{1,0,0,1,25, 17,17,1,0,0,1};
    tbl[8]  = '{1,0,0,0,25, 17,17,1,0,0,0};
    tbl[9]  = '{1,1,1,0,0,  18,6,1,0,0,0};
    tbl[10] = '{0,1,1,1,3,  18,6,1,0,0,0};
    tbl[11] = '{0,1,1,1,3,  18,6,1,0,0,0};
    tbl[12] = '{1,0,1,0,3,  18,6,1,0,0,0};
    tbl[13] = '{1,0,0,1,3,  18,18,1,0,0,0};
    tbl[14] = '{0,0,0,1,3,  18,18,1,0,0,0};
    tbl[15] = '{1,1,1,0,3,  19,7,1,0,0,0};

    // ---- reset and vector table ----
    #3;
    do_reset();
    mode_12h = 1'b1;
    #1;
    check("reset disp 12h", int'(hour_disp), 12);
    check("reset pm 12h", int'(pm), 0);
    for (int i = 0; i < 16; i++) begin
      en = 1'(tbl[i].en); min_carry = 1'(tbl[i].mc); mode_12h = 1'(tbl[i].m12);
      set_req = 1'(tbl[i].sr); set_hour = 5'(tbl[i].sh);
      tick();
      check($sformatf("row%0d hour", i), int'(hour_w), tbl[i].e_hour);
      check($sformatf("row%0d disp", i), int'(hour_disp), tbl[i].e_disp);
      check($sformatf("row%0d pm", i), int'(pm), tbl[i].e_pm);
      check($sformatf("row%0d day_carry", i), int'(day_carry), tbl[i].e_dc);
      check($sformatf("row%0d set_ack", i), int'(set_ack), tbl[i].e_ack);
      check($sformatf("row%0d set_err", i), int'(set_err), tbl[i].e_err);
    end

    // ---- 24 carries from reset: full day wrap ----
    en = 0; min_carry = 0; set_req = 0; mode_12h = 0;
    do_reset();
    en = 1; min_carry = 1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      check($sformatf("wrap step%0d hour", i), int'(hour_w), i % 24);
      check($sformatf("wrap step%0d day_carry", i), int'(day_carry), (i == 24) ? 1 : 0);
    end
    min_carry = 0;
    tick();
    check("wrap day_carry drop", int'(day_carry), 0);

    // ---- set coincident with carry at hour 9; carries ignored while waiting ----
    min_carry = 1;
    for (int i = 0; i < 9; i++) tick();
    check("pre-set hour", int'(hour_w), 9);
    set_req = 1; set_hour = 5'd14;
    tick();
    check("set+carry no increment", int'(hour_w), 9);
    tick();
    check("set+carry load", int'(hour_w), 14);
    check("set+carry ack", int'(set_ack), 1);
    tick();
    check("wait carry ignored", int'(hour_w), 14);
    check("wait ack once", int'(set_ack), 0);
    set_req = 0;
    tick();
    check("drop edge carry ignored", int'(hour_w), 14);
    check("drop edge day_carry", int'(day_carry), 0);

    // ---- disabled carries at 23, then wrap on re-enable ----
    min_carry = 0; set_req = 1; set_hour = 5'd23;
    tick(); tick();
    set_req = 0;
    tick();
    check("set to 23", int'(hour_w), 23);
    en = 0; min_carry = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("en0 hold%0d hour", i), int'(hour_w), 23);
      check($sformatf("en0 hold%0d day_carry", i), int'(day_carry), 0);
    end
    en = 1;
    tick();
    check("re-enable wrap hour", int'(hour_w), 0);
    check("re-enable day_carry", int'(day_carry), 1);
    min_carry = 0;
    tick();
    check("re-enable day_carry drop", int'(day_carry), 0);

    // ---- reset while in LOAD, then display toggling at midnight ----
    min_carry = 1;
    for (int i = 0; i < 5; i++) tick();
    min_carry = 0; set_req = 1; set_hour = 5'd7;
    tick();
    check("pre-reset hour", int'(hour_w), 5);
    do_reset();
    check("after reset in load ack", int'(set_ack), 0);
    set_req = 0;
    tick();
    check("post-reset hour", int'(hour_w), 0);
    check("post-reset ack", int'(set_ack), 0);
    check("post-reset err", int'(set_err), 0);
    min_carry = 1;
    tick();
    check("post-reset run increment", int'(hour_w), 1);
    min_carry = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mode_12h = 1'(i % 2 == 0);
      #1;
      check($sformatf("midnight toggle%0d disp", i), int'(hour_disp), (i % 2 == 0) ? 12 : 0);
      check($sformatf("midnight toggle%0d pm", i), int'(pm), 0);
      check($sformatf("midnight toggle%0d hour", i), int'(hour_w), 0);
    end

    // ---- randomized run against the model ----
    for (int i = 0; i < 1500; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      min_carry = ($urandom_range(0, 2) == 0);
      mode_12h  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) set_req = ~set_req;
      set_hour  = 5'($urandom_range(0, 31));
      tick();
      check_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
